// File: rtl/booth_mul_acc.sv
// Accumulation back end of the Booth radix-4 MAC datapath: sums a programmed
// number of signed products into a wide accumulator, with optional saturation.
module booth_mul_acc #(
   parameter int PROD_W = 16,
   parameter int ACC_W  = 24,
   parameter int LEN_W  = 8,
   parameter int SAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_vld,
   output logic              busy,
   output logic [LEN_W-1:0]  cnt,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_vld,
   output logic              ovf,
   output logic              drop
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};

   state_t             state_r, state_s;
   logic [LEN_W-1:0]   cnt_r, cnt_s;
   logic [ACC_W-1:0]   acc_r, acc_s;
   logic               ovf_r, ovf_s;
   logic               drop_r, drop_s;
   logic               busy_r, busy_s;
   logic               vld_r, vld_s;
   logic [ACC_W:0]     prod_ext_s;
   logic [ACC_W:0]     sum_s;
   logic               sum_ovf_s;

   // Sign-extended add with one guard bit; guard/sign disagreement flags overflow
   always_comb begin
      prod_ext_s = {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
      sum_s      = {acc_r[ACC_W-1], acc_r} + prod_ext_s;
      sum_ovf_s  = sum_s[ACC_W] ^ sum_s[ACC_W-1];
   end

   // Next-state and next-output logic for the job sequencer
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      acc_s   = acc_r;
      ovf_s   = ovf_r;
      drop_s  = drop_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               cnt_s   = len;
               acc_s   = {ACC_W{1'b0}};
               ovf_s   = 1'b0;
               state_s = (len == CNT_ZERO) ? DONE : ACCUM;
            end else begin
               state_s = IDLE;
            end
            // A stray product in the start cycle still marks the new job
            drop_s = prod_vld | (start ? 1'b0 : drop_r);
         end
         ACCUM: begin
            if (prod_vld) begin
               cnt_s   = cnt_r - CNT_ONE;
               ovf_s   = ovf_r | sum_ovf_s;
               state_s = (cnt_r == CNT_ONE) ? DONE : ACCUM;
               if (sum_ovf_s && (SAT != 0)) begin
                  acc_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
               end else begin
                  acc_s = sum_s[ACC_W-1:0];
               end
            end else begin
               state_s = ACCUM;
            end
         end
         DONE: begin
            state_s = IDLE;
            drop_s  = drop_r | prod_vld;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
      vld_s  = (state_s == DONE);
   end

   // State and registered outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= {LEN_W{1'b0}};
         acc_r   <= {ACC_W{1'b0}};
         ovf_r   <= 1'b0;
         drop_r  <= 1'b0;
         busy_r  <= 1'b0;
         vld_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         acc_r   <= acc_s;
         ovf_r   <= ovf_s;
         drop_r  <= drop_s;
         busy_r  <= busy_s;
         vld_r   <= vld_s;
      end
   end

   assign busy    = busy_r;
   assign cnt     = cnt_r;
   assign acc_out = acc_r;
   assign acc_vld = vld_r;
   assign ovf     = ovf_r;
   assign drop    = drop_r;

endmodule
